// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and defaults for the UART TX arbiter
package uart_pkg;
    localparam int DEF_DATA_BITS = 8;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set req at or above ptr with wrap
// Ports: req (request vector), ptr (search start), gnt_onehot / gnt_idx (winner), any (some req set)
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt_onehot,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] idx;
    always_comb begin
        gnt_idx = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) gnt_idx = idx;
        end
        any = |req;
        gnt_onehot = any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte producers
// Ports: req_valid/req_data/req_ready (producers), tx_ready/tx_valid/tx_data (transmitter),
//        grant_id, busy, frame_done, ack_err (status, all registered)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tx_ready,
    output logic                           tx_valid,
    output logic [DATA_BITS-1:0]           tx_data,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           ack_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    arb_state_t state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, gnt_idx, next_ptr;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d, gnt_onehot;
    logic tx_valid_q, tx_valid_d, busy_q, busy_d, frame_done_q, frame_done_d, ack_err_q, ack_err_d, any;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );
    assign next_ptr = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + IW'(1);
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        tx_valid_d   = 1'b0;
        req_ready_d  = '0;
        frame_done_d = 1'b0;
        ack_err_d    = 1'b0;
        case (state_q)
            IDLE: if (any && tx_ready) begin
                state_d     = ISSUE;
                tx_data_d   = req_data[gnt_idx*DATA_BITS +: DATA_BITS];
                tx_valid_d  = 1'b1;
                req_ready_d = gnt_onehot;
                grant_id_d  = gnt_idx;
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                cnt_d   = '0;
            end
            WAIT_BUSY: if (!tx_ready) begin
                state_d = WAIT_DONE;
            end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                // The byte was already acknowledged to its producer, so it is dropped, not retried.
                ack_err_d = 1'b1;
                rr_ptr_d  = next_ptr;
                state_d   = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            WAIT_DONE: if (tx_ready) begin
                frame_done_d = 1'b1;
                rr_ptr_d     = next_ptr;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            tx_data_q    <= '0;
            grant_id_q   <= '0;
            tx_valid_q   <= 1'b0;
            req_ready_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            tx_valid_q   <= tx_valid_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            ack_err_q    <= ack_err_d;
        end
    end
    assign req_ready  = req_ready_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign ack_err    = ack_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a round-robin model
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int DB = 8;
    localparam int AT = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N*DB-1:0] req_data = '0;
    logic tx_ready = 1'b1;
    logic [N-1:0] req_ready;
    logic tx_valid, busy, frame_done, ack_err;
    logic [DB-1:0] tx_data;
    logic [$clog2(N)-1:0] grant_id;
    int passed = 0;
    int total = 0;
    int m_ptr = 0;
    int glog[$];
    int dlog[$];
    always #5 clk = ~clk;
    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .ACK_TIMEOUT(AT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .frame_done (frame_done),
        .ack_err    (ack_err)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    function automatic int pick(input logic [N-1:0] rv, input int p);
        for (int k = 0; k < N; k++) if (rv[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction
    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[i*DB +: DB] = b;
    endtask
    // Expects to be entered at a negedge with the DUT idle and the request inputs already applied.
    task automatic serve(input int blen, input bit stall, input bit keep);
        int w;
        logic [7:0] b;
        w = pick(req_valid, m_ptr);
        b = req_data[w*DB +: DB];
        tick();
        chk("grant_tx_valid", tx_valid, 1);
        chk("grant_req_ready", req_ready, 32'(1) << w);
        chk("grant_id", grant_id, w);
        chk("grant_tx_data", tx_data, b);
        chk("grant_busy", busy, 1);
        glog.push_back(int'(grant_id));
        dlog.push_back(int'(tx_data));
        if (!keep) req_valid[w] = 1'b0;
        if (stall) begin
            for (int i = 1; i <= AT + 1; i++) begin
                tick();
                chk("stall_ack_err", ack_err, i == AT + 1);
                chk("stall_busy", busy, i <= AT);
                chk("stall_pulses", {tx_valid, req_ready, frame_done}, 0);
            end
        end else begin
            tx_ready = 1'b0;
            for (int i = 1; i <= blen; i++) begin
                tick();
                chk("frame_wait", {busy, frame_done, tx_valid, req_ready, ack_err}, 8'h80);
            end
            tx_ready = 1'b1;
            tick();
            chk("frame_done", frame_done, 1);
            chk("frame_idle", {busy, ack_err, tx_valid}, 0);
            chk("tx_data_hold", tx_data, b);
        end
        m_ptr = (w + 1) % N;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        chk("reset_outputs", {req_ready, tx_valid, tx_data, grant_id, busy, frame_done, ack_err}, 0);
        reset = 1'b0;
        m_ptr = 0;
    endtask
    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int exp_data[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        tick();
        do_reset();
        set_byte(2, 8'hA5);
        req_valid = 4'b0100;
        serve(3, 0, 0);
        chk("single_grant", glog[0], 2);
        do_reset();
        glog.delete();
        dlog.delete();
        for (int i = 0; i < N; i++) set_byte(i, 8'((i + 1) * 8'h11));
        req_valid = 4'b1111;
        for (int f = 0; f < 5; f++) serve(2 + f, 0, 1);
        for (int f = 0; f < 5; f++) begin
            chk("rr_order", glog[f], exp_order[f]);
            chk("rr_data", dlog[f], exp_data[f]);
        end
        req_valid = 4'b0100;
        serve(2, 0, 0);
        req_valid = 4'b1001;
        serve(2, 0, 0);
        chk("wrap_first", grant_id, 3);
        serve(3, 0, 0);
        chk("wrap_second", grant_id, 0);
        req_valid = 4'b0010;
        serve(2, 0, 0);
        req_valid = 4'b0001;
        serve(2, 0, 0);
        chk("wrap_ptr2", grant_id, 0);
        req_valid = 4'b0110;
        serve(0, 1, 0);
        chk("stall_victim", glog[glog.size()-1], 1);
        serve(2, 0, 0);
        chk("after_stall", grant_id, 2);
        tx_ready = 1'b0;
        req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_grant_tx_busy", {tx_valid, req_ready, busy}, 0);
        end
        tx_ready = 1'b1;
        serve(2, 0, 0);
        chk("late_grant", grant_id, 3);
        req_valid = 4'b0010;
        serve(2, 0, 0);
        req_valid = 4'b0100;
        tick();
        chk("pre_reset_grant", grant_id, 2);
        req_valid = 4'b0000;
        tx_ready = 1'b0;
        tick();
        tick();
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1 chk("async_reset_outputs", {req_ready, tx_valid, tx_data, grant_id, busy, frame_done, ack_err}, 0);
        tick();
        reset = 1'b0;
        m_ptr = 0;
        tx_ready = 1'b1;
        req_valid = 4'b1010;
        serve(2, 0, 0);
        chk("post_reset_grant", grant_id, 1);
        for (int f = 0; f < 40; f++) begin
            req_valid = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) set_byte(i, 8'($urandom));
            serve(int'($urandom_range(2, 6)), $urandom_range(0, 5) == 0, 0);
            req_valid = '0;
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                tick();
                chk("rand_gap", {busy, tx_valid, req_ready}, 0);
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
